// File: rtl/jh_round_engine_pkg.sv
// Shared definitions for the JH round engine: S-boxes, linear layer L,
// the P_d nibble permutation and the controller state encoding.
package jh_round_engine_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } jh_fsm_e;

  localparam logic [3:0] S0 [16] = '{
    4'h9, 4'h1, 4'hD, 4'h7, 4'h4, 4'h2, 4'h3, 4'h8,
    4'h0, 4'hA, 4'hC, 4'h5, 4'hB, 4'h6, 4'hF, 4'hE
  };

  localparam logic [3:0] S1 [16] = '{
    4'h4, 4'h0, 4'hF, 4'hA, 4'h2, 4'hB, 4'h9, 4'h5,
    4'h8, 4'h3, 4'hD, 4'h7, 4'h1, 4'hE, 4'h6, 4'hC
  };

  // Source nibble of output nibble i for P_d = phi_d o P'_d o pi_d.
  function automatic int perm_idx(input int dim, input int i);
    int h, a, b;
    h = 1 << (dim - 1);
    a = (i < h) ? i : (i ^ 1);
    b = (a < h) ? 2 * a : 2 * (a - h) + 1;
    return ((b % 4) >= 2) ? (b ^ 1) : b;
  endfunction

  // Nibble bit 0 carries element bit A0 of the linear layer.
  function automatic logic [3:0] lin_mix(input logic [3:0] x);
    return {x[0], x[3] ^ x[0], x[2], x[1]};
  endfunction

  // Returns {b_out, a_out} so it packs straight into the state vector.
  function automatic logic [7:0] lin_pair(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] d, c;
    d = b ^ lin_mix(a);
    c = a ^ lin_mix(d);
    return {d, c};
  endfunction

endpackage

// File: rtl/jh_round_engine_if.sv
// Operand/result handshake bundle between the compression wrapper and the engine.
interface jh_round_engine_if #(
  parameter int DIM = 6
);
  localparam int SW = 4 * (2 ** DIM);
  localparam int CW = 2 ** DIM;

  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] state_in;
  logic [CW-1:0] rc_in;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] state_out;

  modport master (
    output in_valid, state_in, rc_in, out_ready,
    input  in_ready, out_valid, state_out
  );

  modport slave (
    input  in_valid, state_in, rc_in, out_ready,
    output in_ready, out_valid, state_out
  );

endinterface

// File: rtl/jh_round_engine_round.sv
// One combinational JH round R_d: per-nibble S-box select, linear layer L, permutation P_d.
module jh_round_engine_round
  import jh_round_engine_pkg::*;
#(
  parameter int DIM = 6
) (
  input  logic [4*(2**DIM)-1:0] state_i,
  input  logic [(2**DIM)-1:0]   sel_i,
  output logic [4*(2**DIM)-1:0] state_o
);

  localparam int N = 2 ** DIM;

  logic [4*N-1:0] lin;

  // Nibble i sits at bits [4i+3:4i]; its S-box select is constant bit N-1-i.
  for (genvar p = 0; p < N / 2; p++) begin : g_pair
    logic [3:0] nib_a, nib_b;
    assign nib_a = sel_i[N-1-2*p] ? S1[state_i[8*p +: 4]]   : S0[state_i[8*p +: 4]];
    assign nib_b = sel_i[N-2-2*p] ? S1[state_i[8*p+4 +: 4]] : S0[state_i[8*p+4 +: 4]];
    assign lin[8*p +: 8] = lin_pair(nib_a, nib_b);
  end

  for (genvar i = 0; i < N; i++) begin : g_perm
    localparam int SRC = perm_idx(DIM, i);
    assign state_o[4*i +: 4] = lin[4*SRC +: 4];
  end

endmodule

// File: rtl/jh_round_engine.sv
// Iterated JH round engine: ROUNDS rounds of R_d, UNROLL per clock, with the
// round constant regenerated on the fly by a dimension DIM-2 all-S0 round.
module jh_round_engine
  import jh_round_engine_pkg::*;
#(
  parameter int DIM    = 6,
  parameter int ROUNDS = 6 * (DIM - 1),
  parameter int UNROLL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  jh_round_engine_if.slave bus
);

  localparam int SW = 4 * (2 ** DIM);
  localparam int CW = 2 ** DIM;
  localparam int RW = $clog2(ROUNDS + 1);

  jh_fsm_e       fsm_q, fsm_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [SW-1:0] state_q, state_d;
  logic [CW-1:0] rc_q, rc_d;
  logic          load;
  logic          last;

  logic [(UNROLL+1)*SW-1:0] st_c;
  logic [(UNROLL+1)*CW-1:0] rc_c;

  assign st_c[SW-1:0] = state_q;
  assign rc_c[CW-1:0] = rc_q;

  // Round u consumes C_u while the constant chain produces C_{u+1} alongside it.
  for (genvar u = 0; u < UNROLL; u++) begin : g_unroll
    jh_round_engine_round #(.DIM(DIM)) u_state (
      .state_i (st_c[u*SW +: SW]),
      .sel_i   (rc_c[u*CW +: CW]),
      .state_o (st_c[(u+1)*SW +: SW])
    );
    jh_round_engine_round #(.DIM(DIM - 2)) u_const (
      .state_i (rc_c[u*CW +: CW]),
      .sel_i   ('0),
      .state_o (rc_c[(u+1)*CW +: CW])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      rcnt_q  <= '0;
      state_q <= '0;
      rc_q    <= '0;
    end else begin
      fsm_q   <= fsm_d;
      rcnt_q  <= rcnt_d;
      state_q <= state_d;
      rc_q    <= rc_d;
    end
  end

  assign last = (int'(rcnt_q) + UNROLL) == ROUNDS;

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      IDLE:    if (bus.in_valid) fsm_d = RUN;
      RUN:     if (last) fsm_d = DONE;
      DONE:    if (bus.out_ready) fsm_d = bus.in_valid ? RUN : IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (fsm_q)
      IDLE: bus.in_ready = 1'b1;
      DONE: begin
        bus.out_valid = 1'b1;
        bus.in_ready  = bus.out_ready;
      end
      default: ;
    endcase
  end

  // The state register doubles as the result register; it only moves in RUN or on a load.
  assign bus.state_out = state_q;
  assign load          = bus.in_valid & bus.in_ready;

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    rcnt_d  = rcnt_q;
    if (load) begin
      state_d = bus.state_in;
      rc_d    = bus.rc_in;
      rcnt_d  = '0;
    end else if (fsm_q == RUN) begin
      state_d = st_c[UNROLL*SW +: SW];
      rc_d    = rc_c[UNROLL*CW +: CW];
      rcnt_d  = rcnt_q + RW'(UNROLL);
    end
  end

endmodule

// File: tb/tb_jh_round_engine.sv
// Bench for jh_round_engine: three configurations driven in lockstep against a
// nibble-array reference model of the JH round.
module tb_jh_round_engine;

  localparam int SW = 256;
  localparam int CW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [SW-1:0] state_in = '0;
  logic [CW-1:0] rc_in = '0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  jh_round_engine_if #(.DIM(6)) bus_a ();
  jh_round_engine_if #(.DIM(6)) bus_b ();
  jh_round_engine_if #(.DIM(6)) bus_c ();

  assign bus_a.in_valid = in_valid;
  assign bus_a.out_ready = out_ready;
  assign bus_a.state_in = state_in;
  assign bus_a.rc_in = rc_in;
  assign bus_b.in_valid = in_valid;
  assign bus_b.out_ready = out_ready;
  assign bus_b.state_in = state_in;
  assign bus_b.rc_in = rc_in;
  assign bus_c.in_valid = in_valid;
  assign bus_c.out_ready = out_ready;
  assign bus_c.state_in = state_in;
  assign bus_c.rc_in = rc_in;

  jh_round_engine #(.DIM(6), .ROUNDS(30), .UNROLL(1)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
  jh_round_engine #(.DIM(6), .ROUNDS(30), .UNROLL(3)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));
  jh_round_engine #(.DIM(6), .ROUNDS(1), .UNROLL(1)) u_c (
    .clk(clk), .rst_n(rst_n), .bus(bus_c.slave));

  localparam logic [3:0] M_S0 [16] = '{
    4'h9, 4'h1, 4'hD, 4'h7, 4'h4, 4'h2, 4'h3, 4'h8,
    4'h0, 4'hA, 4'hC, 4'h5, 4'hB, 4'h6, 4'hF, 4'hE
  };
  localparam logic [3:0] M_S1 [16] = '{
    4'h4, 4'h0, 4'hF, 4'hA, 4'h2, 4'hB, 4'h9, 4'h5,
    4'h8, 4'h3, 4'hD, 4'h7, 4'h1, 4'hE, 4'h6, 4'hC
  };

  task automatic check_eq(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference round at dimension d: S-boxes, L per pair, then pi, P', phi as array moves.
  function automatic logic [SW-1:0] m_round(input logic [SW-1:0] s, input logic [CW-1:0] c, input int d);
    int n;
    logic [3:0] v [64];
    logic [3:0] w [64];
    logic [3:0] x [64];
    logic [3:0] y [64];
    logic [3:0] a, b, cc, dd;
    logic [SW-1:0] r;
    n = 1 << d;
    r = '0;
    for (int i = 0; i < n; i++)
      v[i] = c[n-1-i] ? M_S1[s[4*i +: 4]] : M_S0[s[4*i +: 4]];
    for (int i = 0; i < n / 2; i++) begin
      a = v[2*i];
      b = v[2*i+1];
      dd[0] = b[0] ^ a[1];
      dd[1] = b[1] ^ a[2];
      dd[2] = b[2] ^ a[3] ^ a[0];
      dd[3] = b[3] ^ a[0];
      cc[0] = a[0] ^ dd[1];
      cc[1] = a[1] ^ dd[2];
      cc[2] = a[2] ^ dd[3] ^ dd[0];
      cc[3] = a[3] ^ dd[0];
      v[2*i] = cc;
      v[2*i+1] = dd;
    end
    for (int i = 0; i < n / 4; i++) begin
      w[4*i]   = v[4*i];
      w[4*i+1] = v[4*i+1];
      w[4*i+2] = v[4*i+3];
      w[4*i+3] = v[4*i+2];
    end
    for (int i = 0; i < n / 2; i++) begin
      x[i]       = w[2*i];
      x[i + n/2] = w[2*i+1];
    end
    for (int i = 0; i < n / 2; i++) y[i] = x[i];
    for (int i = n / 2; i < n; i += 2) begin
      y[i]   = x[i+1];
      y[i+1] = x[i];
    end
    for (int i = 0; i < n; i++) r[4*i +: 4] = y[i];
    return r;
  endfunction

  function automatic logic [SW-1:0] m_engine(input logic [SW-1:0] s, input logic [CW-1:0] c, input int rounds);
    logic [SW-1:0] t;
    for (int r = 0; r < rounds; r++) begin
      s = m_round(s, c, 6);
      t = m_round({192'b0, c}, '0, 4);
      c = t[CW-1:0];
    end
    return s;
  endfunction

  function automatic logic [SW-1:0] rnd_sw();
    logic [SW-1:0] v;
    for (int i = 0; i < SW / 32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Offers one job to all three engines, then checks latencies, results and optional backpressure.
  task automatic run_job(input logic [SW-1:0] st, input logic [CW-1:0] rc, input int hold,
                         output logic [SW-1:0] res_c);
    int lat_a, lat_b, lat_c;
    logic [SW-1:0] exp30, exp1;
    lat_a = -1;
    lat_b = -1;
    lat_c = -1;
    exp30 = m_engine(st, rc, 30);
    exp1  = m_engine(st, rc, 1);
    @(negedge clk);
    in_valid = 1'b1;
    state_in = st;
    rc_in = rc;
    out_ready = 1'b1;
    #1 check_eq("accept_ready", SW'(bus_a.in_ready), SW'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (bus_a.out_valid && lat_a < 0) lat_a = n;
      if (bus_b.out_valid && lat_b < 0) lat_b = n;
      if (bus_c.out_valid && lat_c < 0) lat_c = n;
    end
    check_eq("lat_u1", SW'(lat_a), SW'(30));
    check_eq("lat_u3", SW'(lat_b), SW'(10));
    check_eq("lat_r1", SW'(lat_c), SW'(1));
    check_eq("res_u1", bus_a.state_out, exp30);
    check_eq("res_u3", bus_b.state_out, exp30);
    check_eq("res_r1", bus_c.state_out, exp1);
    check_eq("unroll_eq", bus_b.state_out, bus_a.state_out);
    res_c = bus_c.state_out;
    if (hold > 0) begin
      @(negedge clk);
      in_valid = 1'b1;
      state_in = ~st;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        #1;
        check_eq("hold_state", bus_a.state_out, exp30);
        check_eq("hold_valid", SW'(bus_a.out_valid), SW'(1));
        check_eq("hold_in_ready", SW'(bus_a.in_ready), SW'(0));
      end
    end
  endtask

  initial begin
    logic [SW-1:0] res;
    logic [SW-1:0] st;
    logic [CW-1:0] rc;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", SW'(bus_a.out_valid), SW'(0));
    check_eq("rst_state", bus_a.state_out, '0);
    check_eq("rst_in_ready", SW'(bus_a.in_ready), SW'(1));
    @(negedge clk);
    rst_n = 1'b1;

    run_job('0, '0, 0, res);
    check_eq("s0_zero", res, {32{8'h15}});
    run_job('0, '1, 10, res);
    check_eq("s1_zero", res, {32{8'h67}});

    for (int k = 0; k < 150; k++) begin
      st = rnd_sw();
      rc = (k % 2 == 0) ? '0 : {$urandom, $urandom};
      run_job(st, rc, (k % 25 == 0) ? 3 : 0, res);
    end

    // Reset in the middle of a job.
    @(negedge clk);
    in_valid = 1'b1;
    state_in = rnd_sw();
    rc_in = {$urandom, $urandom};
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (12) @(posedge clk);
    #1 check_eq("mr_rcnt_pre", SW'(u_a.rcnt_q), SW'(12));
    #2 rst_n = 1'b0;
    #1;
    check_eq("mr_valid", SW'(bus_a.out_valid), SW'(0));
    check_eq("mr_state", bus_a.state_out, '0);
    check_eq("mr_rcnt", SW'(u_a.rcnt_q), SW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("mr_in_ready", SW'(bus_a.in_ready), SW'(1));
    run_job(rnd_sw(), {$urandom, $urandom}, 0, res);

    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("drain_valid", SW'(bus_a.out_valid), SW'(0));
    check_eq("drain_in_ready", SW'(bus_a.in_ready), SW'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
